seq_magnitude_comparator: RTL



---
 rtl/seq_magnitude_comparator.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/seq_magnitude_comparator.sv
// seq_magnitude_comparator: multi-cycle unsigned WIDTH-bit compare, one
// CHUNK-bit slice per cycle from the top, with valid/ready in and out.
// Ports: clk, rst_n (async, active-low); in_valid/in_ready with a, b;
// out_valid/out_ready with one-hot gt/eq/lt and slices_used.
// Option macro SEQ_CMP_EARLY_EXIT_EN: finish on the first differing slice
// (data-dependent latency); when undefined, always scan all NSLICE slices.
module seq_magnitude_comparator #(
    parameter  int WIDTH  = 256,
    parameter  int CHUNK  = 32,
    localparam int NSLICE = WIDTH / CHUNK,
    localparam int CW     = $clog2(NSLICE + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             gt,
    output logic             eq,
    output logic             lt,
    output logic [CW-1:0]    slices_used
);

    localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    // Operand copies are shifted left each compare cycle so the slice
    // under test always sits in the top CHUNK bits.
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [IW-1:0]    r_idx;
    logic [CW-1:0]    r_cnt;
    logic             r_gt;
    logic             r_eq;
    logic             r_lt;
    logic             r_found;

    logic [CHUNK-1:0] w_sa;
    logic [CHUNK-1:0] w_sb;
    logic             w_diff;
    logic             w_last;
    logic             w_accept;

    assign w_sa     = r_a[WIDTH-1 -: CHUNK];
    assign w_sb     = r_b[WIDTH-1 -: CHUNK];
    assign w_diff   = (w_sa != w_sb);
    assign w_last   = (r_idx == '0);
    assign w_accept = in_valid && (r_state == IDLE);

    assign in_ready    = (r_state == IDLE);
    assign out_valid   = (r_state == DONE);
    assign gt          = r_gt;
    assign eq          = r_eq;
    assign lt          = r_lt;
    assign slices_used = r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_next = COMPARE;
                end
            end
            COMPARE: begin
`ifdef SEQ_CMP_EARLY_EXIT_EN
                if (w_diff || w_last) begin
                    w_next = DONE;
                end
`else
                if (w_last) begin
                    w_next = DONE;
                end
`endif
            end
            DONE: begin
                if (out_ready) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_gt    <= 1'b0;
            r_eq    <= 1'b0;
            r_lt    <= 1'b0;
            r_found <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_idx   <= IW'(NSLICE - 1);
            r_cnt   <= '0;
            r_gt    <= 1'b0;
            r_eq    <= 1'b0;
            r_lt    <= 1'b0;
            r_found <= 1'b0;
        end else if (r_state == COMPARE) begin
            r_cnt <= r_cnt + CW'(1);
            r_a   <= r_a << CHUNK;
            r_b   <= r_b << CHUNK;
            if (!w_last) begin
                r_idx <= r_idx - IW'(1);
            end
            // Only the most significant differing slice decides; once
            // found, lower slices are scanned but cannot change flags.
            if (!r_found) begin
                if (w_diff) begin
                    r_found <= 1'b1;
                    r_gt    <= (w_sa > w_sb);
                    r_lt    <= (w_sa < w_sb);
                end else if (w_last) begin
                    r_eq    <= 1'b1;
                end
            end
        end
    end

endmodule
